tbus_arbiter: RTL and testbench



---
 rtl/tbus_arbiter.sv | 156 +++++++++++++++
 tb/tb_tbus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbus_arbiter.sv
// Two-master round-robin arbiter for the single Trinity bus memory channel.
// One transaction is in flight at a time; its completion is routed back to the owning master.
module tbus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 64,
    parameter int OPT_W   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_index_valid,
    output logic              m0_index_ready,
    input  logic [ADDR_W-1:0] m0_index,
    input  logic [DATA_W-1:0] m0_write_data,
    input  logic [MASK_W-1:0] m0_write_mask,
    input  logic [OPT_W-1:0]  m0_operation_type,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_operation_done,

    input  logic              m1_index_valid,
    output logic              m1_index_ready,
    input  logic [ADDR_W-1:0] m1_index,
    input  logic [DATA_W-1:0] m1_write_data,
    input  logic [MASK_W-1:0] m1_write_mask,
    input  logic [OPT_W-1:0]  m1_operation_type,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              m1_operation_done,

    output logic              tbus_index_valid,
    input  logic              tbus_index_ready,
    output logic [ADDR_W-1:0] tbus_index,
    output logic [DATA_W-1:0] tbus_write_data,
    output logic [MASK_W-1:0] tbus_write_mask,
    output logic [OPT_W-1:0]  tbus_operation_type,
    input  logic [DATA_W-1:0] tbus_read_data,
    input  logic              tbus_operation_done,

    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    state_t      state_next;
    logic        rr_ptr;
    logic        owner;
    logic        winner;
    logic        grant;
    logic        complete;
    logic [31:0] wait_cnt;

    // Winner selection: a lone requester always wins, rr_ptr breaks ties.
    always_comb begin
        grant  = 1'b0;
        winner = 1'b0;
        if (state == IDLE) begin
            grant = m0_index_valid | m1_index_valid;
            if (m0_index_valid && m1_index_valid) begin
                winner = rr_ptr;
            end else begin
                winner = m1_index_valid;
            end
        end
    end

    assign m0_index_ready   = grant & ~winner;
    assign m1_index_ready   = grant & winner;
    assign tbus_index_valid = (state == REQ);
    assign busy             = (state != IDLE);

    // A zero-wait slave may finish in the same cycle it takes the request.
    assign complete = tbus_operation_done &&
                      ((state == WAIT) || (state == REQ && tbus_index_ready));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant) state_next = REQ;
            REQ: begin
                if (complete) begin
                    state_next = IDLE;
                end else if (tbus_index_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner               <= 1'b0;
            tbus_index          <= '0;
            tbus_write_data     <= '0;
            tbus_write_mask     <= '0;
            tbus_operation_type <= '0;
        end else if (grant) begin
            owner               <= winner;
            tbus_index          <= winner ? m1_index          : m0_index;
            tbus_write_data     <= winner ? m1_write_data     : m0_write_data;
            tbus_write_mask     <= winner ? m1_write_mask     : m0_write_mask;
            tbus_operation_type <= winner ? m1_operation_type : m0_operation_type;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr            <= 1'b0;
            m0_read_data      <= '0;
            m1_read_data      <= '0;
            m0_operation_done <= 1'b0;
            m1_operation_done <= 1'b0;
        end else begin
            m0_operation_done <= complete & ~owner;
            m1_operation_done <= complete & owner;
            if (complete) begin
                rr_ptr <= ~owner;
                if (owner) begin
                    m1_read_data <= tbus_read_data;
                end else begin
                    m0_read_data <= tbus_read_data;
                end
            end
        end
    end

    // Timeout only flags the stall; the transaction keeps waiting for its slave.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (complete) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (TIMEOUT != 0 && (wait_cnt + 32'd1) >= 32'(TIMEOUT)) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_tbus_arbiter;

    localparam int TOUT = 8;

    logic        clock;
    logic        reset;
    logic        m0_index_valid, m0_index_ready, m0_operation_done;
    logic [63:0] m0_index, m0_write_data, m0_write_mask, m0_read_data;
    logic [1:0]  m0_operation_type;
    logic        m1_index_valid, m1_index_ready, m1_operation_done;
    logic [63:0] m1_index, m1_write_data, m1_write_mask, m1_read_data;
    logic [1:0]  m1_operation_type;
    logic        tbus_index_valid, tbus_index_ready, tbus_operation_done;
    logic [63:0] tbus_index, tbus_write_data, tbus_write_mask, tbus_read_data;
    logic [1:0]  tbus_operation_type;
    logic        busy, timeout_err;

    int check_count = 0;
    int pass_count  = 0;

    // Model state: one outstanding transaction, whether the slave has taken it yet.
    bit          m_busy, m_presented, m_owner, m_pref, m_err;
    bit          m_done [2];
    logic [63:0] m_rdata [2];
    logic [63:0] m_index, m_wdata, m_mask;
    logic [1:0]  m_op;
    int          m_wait_cycles;

    tbus_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(64), .OPT_W(2), .TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset),
        .m0_index_valid(m0_index_valid), .m0_index_ready(m0_index_ready),
        .m0_index(m0_index), .m0_write_data(m0_write_data), .m0_write_mask(m0_write_mask),
        .m0_operation_type(m0_operation_type), .m0_read_data(m0_read_data),
        .m0_operation_done(m0_operation_done),
        .m1_index_valid(m1_index_valid), .m1_index_ready(m1_index_ready),
        .m1_index(m1_index), .m1_write_data(m1_write_data), .m1_write_mask(m1_write_mask),
        .m1_operation_type(m1_operation_type), .m1_read_data(m1_read_data),
        .m1_operation_done(m1_operation_done),
        .tbus_index_valid(tbus_index_valid), .tbus_index_ready(tbus_index_ready),
        .tbus_index(tbus_index), .tbus_write_data(tbus_write_data),
        .tbus_write_mask(tbus_write_mask), .tbus_operation_type(tbus_operation_type),
        .tbus_read_data(tbus_read_data), .tbus_operation_done(tbus_operation_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic modelReset();
        m_busy = 0; m_presented = 0; m_owner = 0; m_pref = 0; m_err = 0;
        m_done[0] = 0; m_done[1] = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_index = '0; m_wdata = '0; m_mask = '0; m_op = '0;
        m_wait_cycles = 0;
    endtask

    task automatic modelFinish();
        m_rdata[m_owner] = tbus_read_data;
        m_done[m_owner]  = 1;
        m_pref           = !m_owner;
        m_busy           = 0;
        m_presented      = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit w;
        if (reset) begin
            modelReset();
            return;
        end
        m_done[0] = 0;
        m_done[1] = 0;
        if (!m_busy) begin
            if (m0_index_valid || m1_index_valid) begin
                w = (m0_index_valid && m1_index_valid) ? m_pref : m1_index_valid;
                m_index = w ? m1_index          : m0_index;
                m_wdata = w ? m1_write_data     : m0_write_data;
                m_mask  = w ? m1_write_mask     : m0_write_mask;
                m_op    = w ? m1_operation_type : m0_operation_type;
                m_owner = w;
                m_busy = 1;
                m_presented = 1;
            end
        end else if (m_presented) begin
            if (tbus_index_ready) begin
                if (tbus_operation_done) begin
                    modelFinish();
                end else begin
                    m_presented = 0;
                    m_wait_cycles = 0;
                end
            end
        end else if (tbus_operation_done) begin
            modelFinish();
        end else begin
            m_wait_cycles++;
            if (m_wait_cycles >= TOUT) m_err = 1;
        end
    endtask

    // One clock cycle: compare every output against the model, then advance it.
    task automatic applyStimulus();
        bit exp_r0, exp_r1;
        exp_r0 = !m_busy && m0_index_valid && (!m1_index_valid || !m_pref);
        exp_r1 = !m_busy && m1_index_valid && (!m0_index_valid || m_pref);
        @(negedge clock);
        checkOutput("m0_ready", 64'(m0_index_ready), 64'(exp_r0));
        checkOutput("m1_ready", 64'(m1_index_ready), 64'(exp_r1));
        checkOutput("busy", 64'(busy), 64'(m_busy));
        checkOutput("tbus_valid", 64'(tbus_index_valid), 64'(m_busy && m_presented));
        checkOutput("tbus_index", tbus_index, m_index);
        checkOutput("tbus_wdata", tbus_write_data, m_wdata);
        checkOutput("tbus_mask", tbus_write_mask, m_mask);
        checkOutput("tbus_op", 64'(tbus_operation_type), 64'(m_op));
        checkOutput("m0_done", 64'(m0_operation_done), 64'(m_done[0]));
        checkOutput("m1_done", 64'(m1_operation_done), 64'(m_done[1]));
        checkOutput("m0_rdata", m0_read_data, m_rdata[0]);
        checkOutput("m1_rdata", m1_read_data, m_rdata[1]);
        checkOutput("timeout_err", 64'(timeout_err), 64'(m_err));
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        m0_index_valid = 0; m0_index = '0; m0_write_data = '0; m0_write_mask = '0; m0_operation_type = '0;
        m1_index_valid = 0; m1_index = '0; m1_write_data = '0; m1_write_mask = '0; m1_operation_type = '0;
        tbus_index_ready = 0; tbus_operation_done = 0; tbus_read_data = '0;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        reset = 1;
        idleInputs();
        @(posedge clock);
        #1;
        modelReset();
        applyStimulus();
        reset = 0;

        // Single read from m0, slave ready immediately, done two cycles later.
        m0_index_valid = 1; m0_index = 64'h8000_0000; tbus_index_ready = 1;
        #1;
        checkOutput("t1_grant_m0", 64'(m0_index_ready), 64'd1);
        checkOutput("t1_no_grant_m1", 64'(m1_index_ready), 64'd0);
        applyStimulus();
        checkOutput("t1_tbus_valid", 64'(tbus_index_valid), 64'd1);
        checkOutput("t1_tbus_index", tbus_index, 64'h8000_0000);
        m0_index_valid = 0;
        applyStimulus();
        tbus_index_ready = 0;
        applyStimulus();
        tbus_operation_done = 1; tbus_read_data = 64'hDEAD_BEEF;
        applyStimulus();
        checkOutput("t1_done_pulse", 64'(m0_operation_done), 64'd1);
        checkOutput("t1_rdata", m0_read_data, 64'hDEAD_BEEF);
        checkOutput("t1_m1_untouched", m1_read_data, 64'd0);
        tbus_operation_done = 0;
        applyStimulus();
        checkOutput("t1_pulse_ends", 64'(m0_operation_done), 64'd0);

        // Contention with a slave that takes and finishes in the same cycle.
        reset = 1;
        applyStimulus();
        reset = 0;
        m0_index_valid = 1; m1_index_valid = 1;
        tbus_index_ready = 1; tbus_operation_done = 1;
        for (int k = 0; k < 4; k++) begin
            m0_index = rand64(); m1_index = rand64(); tbus_read_data = rand64();
            #1;
            checkOutput($sformatf("rr%0d_m0_ready", k), 64'(m0_index_ready), 64'(k % 2 == 0));
            checkOutput($sformatf("rr%0d_m1_ready", k), 64'(m1_index_ready), 64'(k % 2 == 1));
            applyStimulus();
            checkOutput($sformatf("rr%0d_req", k), 64'(tbus_index_valid), 64'd1);
            applyStimulus();
            checkOutput($sformatf("rr%0d_skip_wait", k), 64'(busy), 64'd0);
            checkOutput($sformatf("rr%0d_done", k),
                        64'((k % 2 == 0) ? m0_operation_done : m1_operation_done), 64'd1);
        end

        // Backpressure: m1 write held for four stalled cycles.
        idleInputs();
        applyStimulus();
        m1_index_valid = 1; m1_index = 64'h100; m1_write_data = 64'h55;
        m1_write_mask = 64'hFF; m1_operation_type = 2'd1;
        applyStimulus();
        m1_index_valid = 0; m1_index = rand64(); m1_write_data = rand64();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d_valid", i), 64'(tbus_index_valid), 64'd1);
            checkOutput($sformatf("bp%0d_index", i), tbus_index, 64'h100);
            checkOutput($sformatf("bp%0d_wdata", i), tbus_write_data, 64'h55);
            checkOutput($sformatf("bp%0d_mask", i), tbus_write_mask, 64'hFF);
            tbus_index_ready = (i == 4);
            applyStimulus();
        end
        checkOutput("bp_wait_valid", 64'(tbus_index_valid), 64'd0);
        checkOutput("bp_wait_busy", 64'(busy), 64'd1);
        tbus_index_ready = 0; tbus_operation_done = 1; tbus_read_data = 64'h1234;
        applyStimulus();
        checkOutput("bp_m1_done", 64'(m1_operation_done), 64'd1);
        checkOutput("bp_m1_rdata", m1_read_data, 64'h1234);
        checkOutput("bp_m0_quiet", 64'(m0_operation_done), 64'd0);
        idleInputs();
        applyStimulus();

        // Random traffic, including stray completions and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            m0_index_valid = ($urandom_range(0, 9) < 6);
            m1_index_valid = ($urandom_range(0, 9) < 6);
            m0_index = rand64(); m0_write_data = rand64(); m0_write_mask = rand64();
            m0_operation_type = 2'($urandom_range(0, 3));
            m1_index = rand64(); m1_write_data = rand64(); m1_write_mask = rand64();
            m1_operation_type = 2'($urandom_range(0, 3));
            tbus_index_ready = $urandom_range(0, 1) == 1;
            tbus_operation_done = (m_busy && !m_presented) ? ($urandom_range(0, 9) < 4)
                                                            : ($urandom_range(0, 9) == 0);
            tbus_read_data = rand64();
            applyStimulus();
        end

        // Timeout: the slave accepts but never completes.
        idleInputs();
        reset = 1;
        applyStimulus();
        reset = 0;
        m0_index_valid = 1; tbus_index_ready = 1;
        applyStimulus();
        m0_index_valid = 0;
        applyStimulus();
        for (int i = 0; i < TOUT - 1; i++) applyStimulus();
        checkOutput("to_not_yet", 64'(timeout_err), 64'd0);
        applyStimulus();
        checkOutput("to_set", 64'(timeout_err), 64'd1);
        checkOutput("to_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("to_sticky", 64'(timeout_err), 64'd1);
        checkOutput("to_still_busy", 64'(busy), 64'd1);

        // Reset while waiting, then a stray completion from the slave.
        reset = 1;
        applyStimulus();
        reset = 0;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(timeout_err), 64'd0);
        tbus_operation_done = 1; tbus_read_data = rand64();
        applyStimulus();
        checkOutput("stray_m0_done", 64'(m0_operation_done), 64'd0);
        checkOutput("stray_m1_done", 64'(m1_operation_done), 64'd0);
        checkOutput("stray_busy", 64'(busy), 64'd0);
        tbus_operation_done = 0;
        m0_index_valid = 1; m1_index_valid = 1;
        #1;
        checkOutput("rst_rr_m0", 64'(m0_index_ready), 64'd1);
        checkOutput("rst_rr_m1", 64'(m1_index_ready), 64'd0);
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
